// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode into a registered control word,
// with a main/skid buffer pair so in_ready comes straight from a flop.
module decode_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   input  logic [31:0] in_pc,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [3:0]  out_alu_op,
   output logic [31:0] out_imm,
   output logic [4:0]  out_rs1,
   output logic [4:0]  out_rs2,
   output logic [4:0]  out_rd,
   output logic [1:0]  out_a_sel,
   output logic [1:0]  out_b_sel,
   output logic        out_reg_write,
   output logic        out_mem_read,
   output logic        out_mem_write,
   output logic        out_branch,
   output logic        out_jump,
   output logic        out_illegal
);

   typedef enum logic [6:0] {
      OPC_LUI      = 7'b0110111,
      OPC_AUIPC    = 7'b0010111,
      OPC_JAL      = 7'b1101111,
      OPC_JALR     = 7'b1100111,
      OPC_BRANCH   = 7'b1100011,
      OPC_LOAD     = 7'b0000011,
      OPC_STORE    = 7'b0100011,
      OPC_OP_IMM   = 7'b0010011,
      OPC_OP       = 7'b0110011,
      OPC_MISC_MEM = 7'b0001111
   } opcode_e;

   typedef enum logic [1:0] {A_RS1 = 2'd0, A_PC = 2'd1, A_ZERO = 2'd2} a_sel_e;
   typedef enum logic [1:0] {B_RS2 = 2'd0, B_IMM = 2'd1, B_FOUR = 2'd2} b_sel_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [3:0]  alu_op;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      a_sel_e      a_sel;
      b_sel_e      b_sel;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        branch;
      logic        jump;
      logic        illegal;
   } ctrl_t;

   ctrl_t       dec;
   opcode_e     opc;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   assign opc   = opcode_e'(in_instr[6:0]);
   assign f3    = in_instr[14:12];
   assign f7    = in_instr[31:25];
   assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
   assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
   assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
   assign imm_u = {in_instr[31:12], 12'h000};
   assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

   always_comb begin
      dec     = '0;
      dec.pc  = in_pc;
      dec.rs1 = in_instr[19:15];
      dec.rs2 = in_instr[24:20];
      dec.rd  = in_instr[11:7];
      case (opc)
         OPC_LUI: begin
            dec.a_sel = A_ZERO; dec.b_sel = B_IMM; dec.imm = imm_u; dec.reg_write = 1'b1;
         end
         OPC_AUIPC: begin
            dec.a_sel = A_PC; dec.b_sel = B_IMM; dec.imm = imm_u; dec.reg_write = 1'b1;
         end
         OPC_JAL: begin
            dec.a_sel = A_PC; dec.b_sel = B_FOUR; dec.imm = imm_j;
            dec.jump  = 1'b1; dec.reg_write = 1'b1;
         end
         OPC_JALR: begin
            dec.a_sel = A_PC; dec.b_sel = B_FOUR; dec.imm = imm_i;
            dec.jump  = 1'b1; dec.reg_write = 1'b1;
            dec.illegal = (f3 != 3'b000);
         end
         OPC_BRANCH: begin
            dec.b_sel  = B_RS2; dec.imm = imm_b; dec.branch = 1'b1;
            case (f3)
               3'b000, 3'b001: dec.alu_op = 4'b1000;
               3'b100, 3'b101: dec.alu_op = 4'b0010;
               3'b110, 3'b111: dec.alu_op = 4'b0011;
               default:        dec.illegal = 1'b1;
            endcase
         end
         OPC_LOAD: begin
            dec.b_sel = B_IMM; dec.imm = imm_i; dec.mem_read = 1'b1; dec.reg_write = 1'b1;
            dec.illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
         end
         OPC_STORE: begin
            dec.b_sel = B_IMM; dec.imm = imm_s; dec.mem_write = 1'b1;
            dec.illegal = (f3 >= 3'b011);
         end
         OPC_OP_IMM: begin
            dec.b_sel = B_IMM; dec.imm = imm_i; dec.reg_write = 1'b1;
            if (f3 == 3'b101) begin
               dec.alu_op  = {in_instr[30], 3'b101};
               dec.illegal = (f7 != 7'b0000000) && (f7 != 7'b0100000);
            end else begin
               dec.alu_op  = {1'b0, f3};
               dec.illegal = (f3 == 3'b001) && (f7 != 7'b0000000);
            end
         end
         OPC_OP: begin
            dec.b_sel = B_RS2; dec.reg_write = 1'b1;
            dec.alu_op  = {in_instr[30], f3};
            dec.illegal = !((f7 == 7'b0000000) ||
                            ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))));
         end
         OPC_MISC_MEM: ;
         default: dec.illegal = 1'b1;
      endcase
      // Illegal words still flow downstream, but must not cause side effects.
      if (dec.illegal) begin
         dec.alu_op    = '0;
         dec.reg_write = 1'b0;
         dec.mem_read  = 1'b0;
         dec.mem_write = 1'b0;
         dec.branch    = 1'b0;
         dec.jump      = 1'b0;
      end
   end

   ctrl_t main_q, main_d, skid_q, skid_d;
   logic  main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
   logic  in_ready_q, in_ready_d;
   logic  accept, consume;

   assign accept  = in_valid && in_ready_q;
   assign consume = main_valid_q && out_ready;

   // in_ready_q is low exactly while the skid entry is occupied.
   always_comb begin
      main_d       = main_q;
      skid_d       = skid_q;
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (skid_valid_q) begin
         if (consume) begin
            main_d       = skid_q;
            skid_valid_d = 1'b0;
         end
      end else if (accept && (!main_valid_q || consume)) begin
         main_d       = dec;
         main_valid_d = 1'b1;
      end else if (accept) begin
         skid_d       = dec;
         skid_valid_d = 1'b1;
      end else if (consume) begin
         main_valid_d = 1'b0;
      end
      in_ready_d = !skid_valid_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_q       <= '0;
         skid_q       <= '0;
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b1;
      end else begin
         main_q       <= main_d;
         skid_q       <= skid_d;
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         in_ready_q   <= in_ready_d;
      end
   end

   assign in_ready      = in_ready_q;
   assign out_valid     = main_valid_q;
   assign out_pc        = main_q.pc;
   assign out_alu_op    = main_q.alu_op;
   assign out_imm       = main_q.imm;
   assign out_rs1       = main_q.rs1;
   assign out_rs2       = main_q.rs2;
   assign out_rd        = main_q.rd;
   assign out_a_sel     = main_q.a_sel;
   assign out_b_sel     = main_q.b_sel;
   assign out_reg_write = main_q.reg_write;
   assign out_mem_read  = main_q.mem_read;
   assign out_mem_write = main_q.mem_write;
   assign out_branch    = main_q.branch;
   assign out_jump      = main_q.jump;
   assign out_illegal   = main_q.illegal;

endmodule
